// File: rtl/mac_cmd_feeder.sv
// mac_cmd_feeder: command queue and issue stage in front of the mac datapath.
// Host commands {instruction, multiplier, multiplicand, repeat} are buffered in
// a circular queue. Each command is issued for repeat+1 non-hold cycles, and NOP
// is issued when the queue is empty. hold freezes the issued command and is
// registered into stall on the same edge.
// Optional feature macro: MAC_CMD_BYPASS_EN. When it is defined, a repeat-0
// command arriving at an empty, non-held queue loads straight into the output
// registers and skips the queue.
module mac_cmd_feeder #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    in_instruction,
    input  logic [15:0]   in_multiplier,
    input  logic [15:0]   in_multiplicand,
    input  logic [3:0]    in_repeat,
    input  logic          hold,
    output logic [2:0]    instruction,
    output logic [15:0]   multiplier,
    output logic [15:0]   multiplicand,
    output logic          stall,
    output logic [AW:0]   count
);

    localparam logic [AW:0]   COUNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   COUNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);

    // Per-edge issue decision; this is a pure function of the current state.
    typedef enum logic [1:0] {
        MODE_IDLE   = 2'd0,
        MODE_ISSUE  = 2'd1,
        MODE_HOLD   = 2'd2,
        MODE_BYPASS = 2'd3
    } mode_t;

    // Queue entry layout: {instruction[38:36], multiplier[35:20], multiplicand[19:4], repeat[3:0]}
    logic [38:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic [3:0]    r_rep_cnt;
    logic [2:0]    r_instruction;
    logic [15:0]   r_multiplier;
    logic [15:0]   r_multiplicand;
    logic          r_stall;

    mode_t         w_mode;
    logic          w_pop;
    logic          w_bypass;
    logic          w_push;
    logic [38:0]   w_head;
    logic [38:0]   w_in_entry;
    logic [34:0]   w_out_next;
    logic [3:0]    w_rep_next;

    assign w_head     = r_mem[r_rd_ptr];
    assign w_in_entry = {in_instruction, in_multiplier, in_multiplicand, in_repeat};
    assign in_ready   = (r_count != COUNT_FULL);
    // A bypassed command is consumed by the output registers, not the queue.
    assign w_push     = in_valid && in_ready && !w_bypass;

    // Decide this edge's action: hold, idle NOP, issue head, or bypass.
    always_comb begin
        w_mode   = MODE_IDLE;
        w_pop    = 1'b0;
        w_bypass = 1'b0;
        if (hold) begin
            w_mode = MODE_HOLD;
        end else if (r_count != '0) begin
            w_mode = MODE_ISSUE;
            w_pop  = (r_rep_cnt == w_head[3:0]);
        end else begin
`ifdef MAC_CMD_BYPASS_EN
            if (in_valid && (in_repeat == 4'd0)) begin
                w_mode   = MODE_BYPASS;
                w_bypass = 1'b1;
            end else begin
                w_mode = MODE_IDLE;
            end
`else
            w_mode = MODE_IDLE;
`endif
        end
    end

    // Next values of the issued command and the head's repeat counter.
    always_comb begin
        w_out_next = {r_instruction, r_multiplier, r_multiplicand};
        w_rep_next = r_rep_cnt;
        case (w_mode)
            MODE_IDLE: begin
                w_out_next = 35'd0;
            end
            MODE_ISSUE: begin
                w_out_next = w_head[38:4];
                w_rep_next = w_pop ? 4'd0 : (r_rep_cnt + 4'd1);
            end
            MODE_BYPASS: begin
                w_out_next = {in_instruction, in_multiplier, in_multiplicand};
            end
            MODE_HOLD: begin
                w_out_next = {r_instruction, r_multiplier, r_multiplicand};
            end
            default: begin
                w_out_next = {r_instruction, r_multiplier, r_multiplicand};
            end
        endcase
    end

    // Issue registers and stall; stall tracks hold so freeze and stall align.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_instruction  <= 3'd0;
            r_multiplier   <= 16'd0;
            r_multiplicand <= 16'd0;
            r_stall        <= 1'b0;
            r_rep_cnt      <= 4'd0;
        end else begin
            {r_instruction, r_multiplier, r_multiplicand} <= w_out_next;
            r_stall   <= hold;
            r_rep_cnt <= w_rep_next;
        end
    end

    // Queue pointers and occupancy; simultaneous push and pop leave count unchanged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + COUNT_ONE;
                2'b01:   r_count <= r_count - COUNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Queue storage; cleared on reset so discarded commands never leak out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 39'd0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_in_entry;
            end
        end
    end

    assign instruction  = r_instruction;
    assign multiplier   = r_multiplier;
    assign multiplicand = r_multiplicand;
    assign stall        = r_stall;
    assign count        = r_count;

endmodule

// File: tb/tb_mac_cmd_feeder.sv
// Self-checking bench for mac_cmd_feeder: directed scenarios plus a randomized
// run compared against a queue-based behavioural model of the command stream.
module tb_mac_cmd_feeder;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_instruction = 3'd0;
    logic [15:0] in_multiplier = 16'd0;
    logic [15:0] in_multiplicand = 16'd0;
    logic [3:0]  in_repeat = 4'd0;
    logic        hold = 1'b0;
    logic [2:0]  instruction;
    logic [15:0] multiplier;
    logic [15:0] multiplicand;
    logic        stall;
    logic [2:0]  count;

    int n_checks = 0;
    int n_fail   = 0;

    mac_cmd_feeder #(.DEPTH(DEPTH), .AW(2)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instruction(in_instruction), .in_multiplier(in_multiplier),
        .in_multiplicand(in_multiplicand), .in_repeat(in_repeat),
        .hold(hold),
        .instruction(instruction), .multiplier(multiplier),
        .multiplicand(multiplicand), .stall(stall), .count(count)
    );

    always #5 clk = ~clk;

    // Behavioural model: a FIFO of commands, each emitted repeat+1 times.
    typedef struct packed {
        logic [2:0]  ins;
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  rep;
    } cmd_t;

    cmd_t        mq[$];
    int          issued = 0;
    logic [2:0]  m_ins = 3'd0;
    logic [15:0] m_a = 16'd0;
    logic [15:0] m_b = 16'd0;
    logic        m_stall = 1'b0;

    always @(posedge clk or posedge reset) begin
        cmd_t c;
        bit   take;
        bit   byp;
        if (reset) begin
            mq.delete();
            issued  = 0;
            m_ins   = 3'd0;
            m_a     = 16'd0;
            m_b     = 16'd0;
            m_stall = 1'b0;
        end else begin
            c    = {in_instruction, in_multiplier, in_multiplicand, in_repeat};
            take = in_valid && (mq.size() < DEPTH);
            byp  = 1'b0;
            m_stall = hold;
            if (!hold) begin
                if (mq.size() == 0) begin
`ifdef MAC_CMD_BYPASS_EN
                    if (in_valid && in_repeat == 4'd0) begin
                        byp = 1'b1;
                        m_ins = c.ins; m_a = c.a; m_b = c.b;
                    end else
`endif
                    begin
                        m_ins = 3'd0; m_a = 16'd0; m_b = 16'd0;
                    end
                end else begin
                    m_ins = mq[0].ins; m_a = mq[0].a; m_b = mq[0].b;
                    issued++;
                    if (issued == int'(mq[0].rep) + 1) begin
                        void'(mq.pop_front());
                        issued = 0;
                    end
                end
            end
            if (take && !byp) mq.push_back(c);
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [2:0] ins, input logic [15:0] a,
                         input logic [15:0] b, input logic [3:0] rep);
        in_valid = v; in_instruction = ins; in_multiplier = a;
        in_multiplicand = b; in_repeat = rep;
    endtask

    task automatic test_reset();
        n_checks++;
        if ({instruction, multiplier, multiplicand, stall, count, in_ready} !== {38'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_state: got %h/%h/%h st=%b cnt=%0d rdy=%b expected all 0, rdy=1",
                     instruction, multiplier, multiplicand, stall, count, in_ready);
        end
        reset = 1'b0;
        drive(1'b1, 3'd1, 16'd6, 16'd25, 4'd3);
        tick();
        drive(1'b0, 3'd0, 16'd0, 16'd0, 4'd0);
        tick();
        tick();
        n_checks++;
        if ({instruction, multiplier, multiplicand} !== {3'd1, 16'd6, 16'd25}) begin
            n_fail++;
            $display("FAIL reset_midissue_pre: got %h/%h/%h expected 1/0006/0019",
                     instruction, multiplier, multiplicand);
        end
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if ({instruction, multiplier, multiplicand, stall, count, in_ready} !== {38'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_async: got %h/%h/%h st=%b cnt=%0d rdy=%b expected all 0, rdy=1",
                     instruction, multiplier, multiplicand, stall, count, in_ready);
        end
        @(negedge clk);
        reset = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({instruction, multiplier, multiplicand, count} !== 38'd0) begin
            n_fail++;
            $display("FAIL reset_after_nop: got %h/%h/%h cnt=%0d expected NOP, cnt=0",
                     instruction, multiplier, multiplicand, count);
        end
    endtask

    task automatic test_single_repeat();
        logic [34:0] obs [6];
        logic [34:0] exp_seq [6];
        logic [34:0] cmd_a;
        logic [34:0] cmd_b;
        cmd_a = {3'd1, 16'd6, 16'd25};
        cmd_b = {3'd2, 16'hFFFC, 16'd5};
`ifdef MAC_CMD_BYPASS_EN
        exp_seq = '{cmd_a, 35'd0, cmd_b, cmd_b, 35'd0, 35'd0};
`else
        exp_seq = '{35'd0, cmd_a, cmd_b, cmd_b, 35'd0, 35'd0};
`endif
        drive(1'b1, 3'd1, 16'd6, 16'd25, 4'd0);
        tick();
        obs[0] = {instruction, multiplier, multiplicand};
        drive(1'b1, 3'd2, -16'sd4, 16'd5, 4'd1);
        tick();
        obs[1] = {instruction, multiplier, multiplicand};
        drive(1'b0, 3'd0, 16'd0, 16'd0, 4'd0);
        for (int i = 2; i < 6; i++) begin
            tick();
            obs[i] = {instruction, multiplier, multiplicand};
        end
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (obs[i] !== exp_seq[i]) begin
                n_fail++;
                $display("FAIL single_repeat[%0d]: got %h expected %h", i, obs[i], exp_seq[i]);
            end
        end
    endtask

    task automatic test_full();
        hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 3'(i + 1), 16'(100 + i), 16'(200 + i), 4'd0);
            tick();
            if (i == 3) begin
                n_checks++;
                if ({in_ready, count} !== {1'b0, 3'd4}) begin
                    n_fail++;
                    $display("FAIL full_after4: got rdy=%b cnt=%0d expected rdy=0 cnt=4", in_ready, count);
                end
            end
        end
        n_checks++;
        if ({count, stall, instruction} !== {3'd4, 1'b1, 3'd0}) begin
            n_fail++;
            $display("FAIL full_refuse5: got cnt=%0d st=%b ins=%0d expected cnt=4 st=1 ins=0",
                     count, stall, instruction);
        end
        hold = 1'b0;
        tick();
        n_checks++;
        if ({count, stall, instruction} !== {3'd3, 1'b0, 3'd1}) begin
            n_fail++;
            $display("FAIL full_first_pop: got cnt=%0d st=%b ins=%0d expected cnt=3 st=0 ins=1",
                     count, stall, instruction);
        end
        tick();
        n_checks++;
        if ({count, instruction} !== {3'd3, 3'd2}) begin
            n_fail++;
            $display("FAIL full_accept5: got cnt=%0d ins=%0d expected cnt=3 ins=2", count, instruction);
        end
        drive(1'b0, 3'd0, 16'd0, 16'd0, 4'd0);
        for (int i = 3; i <= 6; i++) begin
            tick();
            n_checks++;
            if (instruction !== 3'(i % 6)) begin
                n_fail++;
                $display("FAIL full_drain[%0d]: got ins=%0d expected %0d", i, instruction, i % 6);
            end
        end
    endtask

    task automatic test_hold_mid_repeat();
        int issues;
        logic [34:0] cmd;
        cmd = {3'd5, 16'h0808, 16'h0408};
        drive(1'b1, 3'd5, 16'h0808, 16'h0408, 4'd2);
        tick();
        drive(1'b0, 3'd0, 16'd0, 16'd0, 4'd0);
        tick();
        issues = ({instruction, multiplier, multiplicand} == cmd && !stall) ? 1 : 0;
        hold = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if ({stall, instruction, multiplier, multiplicand} !== {1'b1, cmd}) begin
                n_fail++;
                $display("FAIL hold_frozen[%0d]: got st=%b %h expected st=1 %h",
                         i, stall, {instruction, multiplier, multiplicand}, cmd);
            end
        end
        hold = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if ({instruction, multiplier, multiplicand} == cmd && !stall) issues++;
        end
        n_checks++;
        if (issues !== 3) begin
            n_fail++;
            $display("FAIL hold_issue_total: got %0d expected 3", issues);
        end
    endtask

    task automatic test_wrap();
        logic [34:0] cmds [10];
        logic [34:0] obs [13];
        int lat;
        int bad_count;
        logic [2:0] steady;
`ifdef MAC_CMD_BYPASS_EN
        lat = 0; steady = 3'd0;
`else
        lat = 1; steady = 3'd1;
`endif
        bad_count = 0;
        for (int i = 0; i < 10; i++) begin
            cmds[i] = {3'(1 + i % 7), 16'($urandom), 16'($urandom)};
        end
        for (int i = 0; i < 13; i++) begin
            if (i < 10) drive(1'b1, cmds[i][34:32], cmds[i][31:16], cmds[i][15:0], 4'd0);
            else drive(1'b0, 3'd0, 16'd0, 16'd0, 4'd0);
            tick();
            obs[i] = {instruction, multiplier, multiplicand};
            if (i >= 1 && i <= 9 && count !== steady) bad_count++;
        end
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (obs[i + lat] !== cmds[i]) begin
                n_fail++;
                $display("FAIL wrap_seq[%0d]: got %h expected %h", i, obs[i + lat], cmds[i]);
            end
        end
        n_checks++;
        if (bad_count !== 0) begin
            n_fail++;
            $display("FAIL wrap_count_stable: got %0d unstable cycles expected 0", bad_count);
        end
    endtask

    task automatic test_empty_hold();
        hold = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({instruction, multiplier, multiplicand, stall} !== {35'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL empty_hold_nop: got %h st=%b expected NOP st=1",
                     {instruction, multiplier, multiplicand}, stall);
        end
        drive(1'b1, 3'd3, 16'd7, 16'd9, 4'd0);
        tick();
        drive(1'b0, 3'd0, 16'd0, 16'd0, 4'd0);
        n_checks++;
        if ({count, instruction, stall} !== {3'd1, 3'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL empty_hold_push: got cnt=%0d ins=%0d st=%b expected cnt=1 ins=0 st=1",
                     count, instruction, stall);
        end
        tick();
        hold = 1'b0;
        tick();
        n_checks++;
        if ({instruction, multiplier, multiplicand, stall} !== {3'd3, 16'd7, 16'd9, 1'b0}) begin
            n_fail++;
            $display("FAIL empty_hold_release: got %h st=%b expected %h st=0",
                     {instruction, multiplier, multiplicand}, stall, {3'd3, 16'd7, 16'd9});
        end
        tick();
        n_checks++;
        if ({instruction, count} !== {3'd0, 3'd0}) begin
            n_fail++;
            $display("FAIL empty_hold_after: got ins=%0d cnt=%0d expected 0/0", instruction, count);
        end
    endtask

    task automatic test_random();
        logic [39:0] got;
        logic [39:0] exp_v;
        int errs;
        errs = 0;
        for (int i = 0; i < 400; i++) begin
            hold = ($urandom_range(0, 3) == 0);
            drive($urandom_range(0, 2) != 0, 3'($urandom), 16'($urandom), 16'($urandom),
                  ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 3)));
            tick();
            got   = {instruction, multiplier, multiplicand, stall, count, in_ready};
            exp_v = {m_ins, m_a, m_b, m_stall, 3'(mq.size()), (mq.size() != DEPTH)};
            n_checks++;
            if (got !== exp_v) begin
                n_fail++;
                errs++;
                if (errs <= 5) $display("FAIL random[%0d]: got %h expected %h", i, got, exp_v);
            end
        end
        hold = 1'b0;
        drive(1'b0, 3'd0, 16'd0, 16'd0, 4'd0);
    endtask

    initial begin
        reset = 1'b1;
        tick();
        tick();
        test_reset();
        test_single_repeat();
        test_full();
        test_hold_mid_repeat();
        test_wrap();
        test_empty_hold();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mac_cmd_feeder.md
# mac_cmd_feeder

Command queue and issue stage directly upstream of the `mac` datapath. It buffers {instruction, multiplier, multiplicand, repeat} commands from the host over a valid/ready handshake. Each command is issued to the MAC for `repeat+1` consecutive cycles, and NOP (instruction 0) is issued when the queue is empty. A downstream `hold` request is converted into the registered `stall` the MAC consumes, freezing the issued command in the same cycle.

## Interface
Parameters:
- `DEPTH`, 4: queue entries; power of two, ≥2.
- `AW`, 2: log2(DEPTH).

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  host command valid.
- `in_ready`  out  1  queue can accept; combinational, `count != DEPTH`.
- `in_instruction`  in  3  MAC opcode (0 = NOP, 1..7 passed through).
- `in_multiplier`  in  16  operand A.
- `in_multiplicand`  in  16  operand B.
- `in_repeat`  in  4  extra issue cycles; 0 = issue once, 15 = issue 16 times.
- `hold`  in  1  downstream back-pressure request.
- `instruction`  out  3  registered opcode to MAC.
- `multiplier`  out  16  registered operand A to MAC.
- `multiplicand`  out  16  registered operand B to MAC.
- `stall`  out  1  registered; `stall <= hold` every edge.
- `count`  out  AW+1  current queue occupancy.

## Operation
- Storage: circular buffer of DEPTH entries of 39 bits, with write pointer, read pointer, `count`, and a 4-bit `rep_cnt` for the head entry.
- Push: occurs at an edge when `in_valid && in_ready`. A full queue refuses the push even if a pop happens in the same cycle.
- Issue state machine, evaluated each edge:
  - **HOLD**: if `hold`=1, output registers, `rep_cnt`, and the read pointer are unchanged. Pushes still proceed.
  - **IDLE**: if `hold`=0 and `count`=0, outputs load 0/0/0 (NOP).
  - **ISSUE**: if `hold`=0 and `count`>0, outputs load the head entry.
    - If `rep_cnt == head.repeat`: pop the head and set `rep_cnt` to 0.
    - Otherwise: increment `rep_cnt`.
- Same-edge push and pop: `count` is unchanged, and both pointers advance modulo DEPTH.
- Pointers wrap from DEPTH-1 to 0.
- Operands pass through unmodified; there is no sign or width conversion.
- Reset, asynchronous, valid at any point including mid-repeat:
  - Pointers, `count`, and `rep_cnt` clear to 0.
  - `instruction`, `multiplier`, `multiplicand`, and `stall` clear to 0.
  - `in_ready` reads 1.
  - Queued commands are discarded.

## Timing
- Latency, empty queue, no hold: command accepted at edge N appears on the outputs after edge N+1. That is 2 cycles from acceptance.
- Back-to-back commands with `repeat`=0 issue one per cycle, with no bubbles.
- Command with `repeat`=R occupies the outputs for exactly R+1 non-hold cycles.
- Freeze alignment: `stall` rises at the same edge the outputs freeze, so the MAC sees a stalled, frozen command together. The first non-hold edge after `hold` falls resumes issue and clears `stall` together.
- `count` and `in_ready` update at the push/pop edge.

## Configuration
- `MAC_CMD_BYPASS_EN` defined: bypass applies when all of these hold at an edge:
  - `count`=0
  - `hold`=0
  - `in_valid`=1
  - `in_repeat`=0

  In that case the command loads directly into the output registers at the acceptance edge (latency 1 cycle) and is not written to the queue. `in_ready` behaviour is unchanged.
- Undefined: every command passes through the queue, with the 2-cycle minimum latency above.

## Test plan
- **Reset**: assert `reset` mid-issue of {1, 6, 25, repeat 3}.
  - Outputs and `count` must be 0 immediately, before the next edge.
  - After release, NOP is issued.
- **Single and repeat**: push {1, 6, 25, repeat 0}, then {2, −4, 5, repeat 1}.
  - Outputs are 1/6/25 for 1 cycle, then 2/0xFFFC/5 for 2 cycles, then NOP.
  - First issue is 2 cycles after acceptance (1 cycle with `MAC_CMD_BYPASS_EN`).
- **Full**: hold `hold`=1 and push 5 commands.
  - `in_ready` drops after the 4th push and `count` = 4.
  - The 5th command is not accepted until a pop occurs.
- **Hold mid-repeat**: command {5, 0x0808, 0x0408, repeat 2}, with `hold`=1 for 2 cycles after its first issue.
  - `stall`=1 and outputs stay frozen for 2 cycles.
  - Total issue cycles remain 3.
- **Wrap and concurrency**: stream 10 commands with `repeat` 0, with `in_valid` continuously high and no hold.
  - Pointers wrap and `count` stays stable with simultaneous push/pop.
  - Issued sequence matches push order exactly, with no gaps.
- **Empty-queue hold**: `hold`=1 while idle.
  - NOP persists with `stall`=1.
  - A command pushed during the hold issues on the first edge after `hold` falls.
